// File: rtl/mac_accumulator.sv
// mac_accumulator: registered multiply-accumulate back end for wallace_tree_multiplier.
// Accepts 2N-bit unsigned products over a valid/ready handshake, sums a programmed
// number of them into an ACC_W-bit accumulator, then offers the result downstream.
// Optional build macro: MAC_ACCUMULATOR_SAT_EN -- clamp the accumulator to all-ones
// on carry out instead of wrapping. The overflow flag behaves the same in both builds.
module mac_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N-1:0]     product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic               overflow,
  output logic               busy
);

  // A narrower accumulator could not hold even a single product.
  generate
    if (ACC_W < 2*N) begin : g_width_check
      $error("mac_accumulator: ACC_W must be >= 2*N");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;

  // One extra bit on the sum exposes the carry out of the accumulator.
  logic [ACC_W:0]     sum;
  logic               carry;
  logic               last_term;

  assign sum       = {1'b0, acc_q} + (ACC_W+1)'(product);
  assign carry     = sum[ACC_W];
  assign last_term = (count_q == (len_q - CNT_W'(1)));

  // State register and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; every register holds unless a case updates it.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          if (len != '0) begin
            len_d   = len;
            state_d = S_ACCUM;
          end else begin
            // Empty job: report a zero result straight away.
            state_d = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone marks a handshake.
        if (in_valid) begin
`ifdef MAC_ACCUMULATOR_SAT_EN
          // Once at all-ones any non-zero add carries again, so the clamp persists.
          acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          if (carry) begin
            ovf_d = 1'b1;
          end
          count_d = count_q + CNT_W'(1);
          if (last_term) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // start is deliberately ignored here, even during the output handshake.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are pure state decode or registers: no combinational input-to-output path.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Testbench for mac_accumulator: table of jobs driven through a scoreboard queue,
// plus hand-written sequences for reset state and an asynchronous reset mid-job.
module tb_mac_accumulator;

  localparam int N     = 8;
  localparam int ACC_W = 24;
  localparam int CNT_W = 10;  // wide enough for the 258/259-term overflow jobs

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [CNT_W-1:0]   len;
  logic               in_valid;
  logic               in_ready;
  logic [2*N-1:0]     product;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   acc_out;
  logic               overflow;
  logic               busy;

  int total = 0;
  int bad   = 0;

  mac_accumulator #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    int                 len;
    logic [3:0][15:0]   p;       // product for handshake k is p[k % 4]
    logic [7:0]         vpat;    // in_valid for feed cycle c is vpat[c % 8]
    logic [ACC_W-1:0]   exp_acc;
    logic               exp_ovf;
    int                 hold;    // cycles of out_ready=0 (with start pulses) in DONE
  } vec_t;

  typedef struct {
    logic [ACC_W-1:0]   acc;
    logic               ovf;
  } exp_t;

  exp_t sb_q[$];
  vec_t vt[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  task automatic run_job(input vec_t v);
    int   n;
    int   cyc;
    exp_t e;
    exp_t got;
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(v.len);
    e.acc = v.exp_acc;
    e.ovf = v.exp_ovf;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n   = 0;
    cyc = 0;
    while (n < v.len && cyc < 2000) begin
      in_valid = v.vpat[cyc % 8];
      product  = v.p[n % 4];
      if (in_valid && in_ready) n++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({v.name, " handshakes"}, 32'(n), 32'(v.len));
    // One cycle after the final handshake (or after start for an empty job).
    check({v.name, " latency out_valid"}, 32'(out_valid), 32'd1);
    check({v.name, " in_ready low in DONE"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < v.hold; i++) begin
      start = 1'b1;
      check({v.name, " held out_valid"}, 32'(out_valid), 32'd1);
      check({v.name, " held acc_out"}, 32'(acc_out), 32'(v.exp_acc));
      @(negedge clk);
    end
    out_ready = 1'b1;
    start     = (v.hold > 0);
    if (sb_q.size() == 0) begin
      check({v.name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      got.acc = acc_out;
      got.ovf = overflow;
      e = sb_q.pop_front();
      check({v.name, " acc_out"}, 32'(got.acc), 32'(e.acc));
      check({v.name, " overflow"}, 32'(got.ovf), 32'(e.ovf));
    end
    check({v.name, " busy in DONE"}, 32'(busy), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check({v.name, " busy after drain"}, 32'(busy), 32'd0);
    check({v.name, " out_valid after drain"}, 32'(out_valid), 32'd0);
    if (v.hold > 0) begin
      @(negedge clk);
      check({v.name, " start in DONE ignored"}, 32'(busy), 32'd0);
    end
  endtask

  // Hard bound on the whole run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{name: "basic", len: 3, p: {16'd0, 16'd1, 16'd100, 16'd65025}, vpat: 8'hFF,
              exp_acc: 24'd65126, exp_ovf: 1'b0, hold: 0};
    vt[1] = '{name: "empty", len: 0, p: '0, vpat: 8'hFF,
              exp_acc: 24'd0, exp_ovf: 1'b0, hold: 0};
    vt[2] = '{name: "gaps", len: 4, p: {16'd7, 16'd7, 16'd7, 16'd7}, vpat: 8'h59,
              exp_acc: 24'd28, exp_ovf: 1'b0, hold: 5};
`ifdef MAC_ACCUMULATOR_SAT_EN
    vt[3] = '{name: "ovf259", len: 259, p: {4{16'd65025}}, vpat: 8'hFF,
              exp_acc: 24'd16777215, exp_ovf: 1'b1, hold: 0};
`else
    vt[3] = '{name: "ovf259", len: 259, p: {4{16'd65025}}, vpat: 8'hFF,
              exp_acc: 24'd64259, exp_ovf: 1'b1, hold: 0};
`endif
    vt[4] = '{name: "edge258", len: 258, p: {4{16'd65025}}, vpat: 8'hFF,
              exp_acc: 24'd16776450, exp_ovf: 1'b0, hold: 0};
    vt[5] = '{name: "small", len: 2, p: {16'd0, 16'd0, 16'd6, 16'd5}, vpat: 8'hFF,
              exp_acc: 24'd11, exp_ovf: 1'b0, hold: 0};

    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    product   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset acc_out", 32'(acc_out), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_job(vt[i]);
    end

    // Asynchronous reset two terms into a five-term job.
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(5);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    product  = 16'd9;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("midjob acc before reset", 32'(acc_out), 32'd18);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset in_ready", 32'(in_ready), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset acc_out", 32'(acc_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job('{name: "after reset", len: 1, p: {16'd0, 16'd0, 16'd0, 16'd9}, vpat: 8'hFF,
              exp_acc: 24'd9, exp_ovf: 1'b0, hold: 0});

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
